alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Grants one requester, drives its operation to the ALU, captures result and flags one cycle later.
module alu_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [3:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [3:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cf,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  // last_q: requester granted most recently; owner_q: requester whose op is in flight
  logic             last_q;
  logic             last_d;
  logic             owner_q;
  logic             owner_d;
  logic             win_c;
  logic             any_req_c;

  logic             gnt0_d;
  logic             gnt1_d;
  logic             done0_d;
  logic             done1_d;
  logic             busy_d;
  logic [3:0]       alu_op_d;
  logic [WIDTH-1:0] alu_a_d;
  logic [WIDTH-1:0] alu_b_d;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;

  // On a tie the requester not granted last wins; otherwise the sole requester wins
  assign any_req_c = req0 | req1;
  assign win_c     = (req0 & req1) ? ~last_q : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req_c) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    busy_d   = 1'b0;
    alu_op_d = alu_op;
    alu_a_d  = alu_a;
    alu_b_d  = alu_b;
    res_d    = res;
    flags_d  = flags;
    last_d   = last_q;
    owner_d  = owner_q;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          gnt0_d   = ~win_c;
          gnt1_d   = win_c;
          busy_d   = 1'b1;
          alu_op_d = win_c ? op1 : op0;
          alu_a_d  = win_c ? a1 : a0;
          alu_b_d  = win_c ? b1 : b0;
          last_d   = win_c;
          owner_d  = win_c;
        end
      end
      EXEC: begin
        res_d   = alu_out;
        flags_d = {alu_cf, alu_zf, alu_sf, alu_of};
        done0_d = ~owner_q;
        done1_d = owner_q;
      end
      default: ;
    endcase
  end

  // Reset clears everything, which also aborts an op in flight without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
      alu_op  <= 4'b0000;
      alu_a   <= '0;
      alu_b   <= '0;
      res     <= '0;
      flags   <= 4'b0000;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      done0   <= done0_d;
      done1   <= done1_d;
      busy    <= busy_d;
      alu_op  <= alu_op_d;
      alu_a   <= alu_a_d;
      alu_b   <= alu_b_d;
      res     <= res_d;
      flags   <= flags_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus transaction-level arbiter model,
// directed scenarios followed by randomized two-requester traffic.
module tb_alu_arbiter;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         req0, req1;
  logic [3:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic         alu_cf, alu_zf, alu_sf, alu_of;
  logic [W-1:0] res;
  logic [3:0]   flags;

  logic         r_req [2];
  logic [3:0]   r_op  [2];
  logic [W-1:0] r_a   [2];
  logic [W-1:0] r_b   [2];

  assign req0 = r_req[0];
  assign op0  = r_op[0];
  assign a0   = r_a[0];
  assign b0   = r_b[0];
  assign req1 = r_req[1];
  assign op1  = r_op[1];
  assign a1   = r_a[1];
  assign b1   = r_b[1];

  int tests;
  int errors;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .res(res), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: returns {result, CF, ZF, SF, OF}; unknown opcodes give zero
  function automatic logic [W+3:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         cf, of;
    t = '0; r = '0; cf = 1'b0; of = 1'b0;
    case (op)
      4'd1: begin
        t  = {1'b0, a} + {1'b0, b};
        r  = t[W-1:0];
        cf = t[W];
        of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd2: begin
        t  = {1'b0, a} - {1'b0, b};
        r  = t[W-1:0];
        cf = t[W];
        of = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = ~a;
      default: r = '0;
    endcase
    return {r, cf, (r == '0), r[W-1], of};
  endfunction

  always_comb {alu_out, alu_cf, alu_zf, alu_sf, alu_of} = alu_fn(alu_op, alu_a, alu_b);

  // Reference model state
  bit           m_exec;
  int           m_last;
  int           m_owner;
  logic [1:0]   exp_gnt, exp_done;
  logic         exp_busy;
  logic [3:0]   exp_op;
  logic [W-1:0] exp_a, exp_b, exp_res;
  logic [3:0]   exp_flags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_exec = 1'b0; m_last = 1; m_owner = 0;
    exp_gnt = 2'b00; exp_done = 2'b00; exp_busy = 1'b0;
    exp_op = 4'h0; exp_a = '0; exp_b = '0; exp_res = '0; exp_flags = 4'h0;
  endtask

  // Predicts the effect of the coming clock edge from the current requests
  task automatic model_step();
    int win;
    exp_gnt = 2'b00; exp_done = 2'b00; exp_busy = 1'b0;
    if (!m_exec) begin
      if (r_req[0] || r_req[1]) begin
        if (r_req[0] && r_req[1]) win = 1 - m_last;
        else win = r_req[0] ? 0 : 1;
        m_last = win; m_owner = win; m_exec = 1'b1;
        exp_gnt[win] = 1'b1;
        exp_busy = 1'b1;
        exp_op = r_op[win]; exp_a = r_a[win]; exp_b = r_b[win];
      end
    end else begin
      {exp_res, exp_flags} = alu_fn(exp_op, exp_a, exp_b);
      exp_done[m_owner] = 1'b1;
      m_exec = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("gnt",    32'({gnt1, gnt0}),   32'(exp_gnt));
    check("done",   32'({done1, done0}), 32'(exp_done));
    check("busy",   32'(busy),           32'(exp_busy));
    check("alu_op", 32'(alu_op),         32'(exp_op));
    check("alu_a",  32'(alu_a),          32'(exp_a));
    check("alu_b",  32'(alu_b),          32'(exp_b));
    check("res",    32'(res),            32'(exp_res));
    check("flags",  32'(flags),          32'(exp_flags));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic rq, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    r_req[i] = rq; r_op[i] = op; r_a[i] = a; r_b[i] = b;
  endtask

  int order[$];

  initial begin
    tests = 0; errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 4'h0, '0, '0);
    model_reset();
    @(negedge clk);
    do_reset();

    // Add with signed overflow from requester 0
    set_req(0, 1'b1, 4'b0001, 16'h7FFF, 16'h0001);
    cycle();
    check("d_add_gnt0", 32'(gnt0), 32'd1);
    r_req[0] = 1'b0;
    cycle();
    check("d_add_done0", 32'(done0), 32'd1);
    check("d_add_res", 32'(res), 32'h8000);
    check("d_add_flags", 32'(flags), 32'b0011);

    // Subtract to zero from requester 1
    set_req(1, 1'b1, 4'b0010, 16'h0005, 16'h0005);
    cycle();
    check("d_sub_gnt1", 32'(gnt1), 32'd1);
    r_req[1] = 1'b0;
    cycle();
    check("d_sub_done1", 32'(done1), 32'd1);
    check("d_sub_res", 32'(res), 32'h0000);
    check("d_sub_zf_sf", 32'(flags[2:1]), 32'b10);

    // Both held high after reset: strict alternation starting with requester 0
    do_reset();
    set_req(0, 1'b1, 4'd4, 16'h1200, 16'h0034);
    set_req(1, 1'b1, 4'd5, 16'hFFFF, 16'h00FF);
    order.delete();
    for (int c = 0; c < 8; c++) begin
      cycle();
      check("d_rr_nooverlap", 32'(gnt0 & gnt1 | done0 & done1), 32'd0);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    check("d_rr_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size() && k < 4; k++)
      check("d_rr_order", 32'(order[k]), 32'(k % 2));

    // Operands latched at grant
    set_req(0, 1'b1, 4'b0011, 16'hF0F0, 16'h0FF0);
    cycle();
    r_req[0] = 1'b0; r_a[0] = 16'h0000;
    cycle();
    check("d_latch_res", 32'(res), 32'h00F0);

    // Asynchronous reset in the execute cycle aborts the operation
    set_req(1, 1'b1, 4'd4, 16'hABCD, 16'h0001);
    cycle();
    r_req[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("d_abort_done", 32'({done1, done0}), 32'd0);
    check("d_abort_res", 32'(res), 32'd0);
    check("d_abort_flags", 32'(flags), 32'd0);
    check("d_abort_busy", 32'(busy), 32'd0);
    check("d_abort_alu_op", 32'(alu_op), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Undefined opcode passes through
    set_req(0, 1'b1, 4'b1111, 16'h1234, 16'h5678);
    cycle();
    check("d_undef_op", 32'(alu_op), 32'hF);
    r_req[0] = 1'b0;
    cycle();
    check("d_undef_done0", 32'(done0), 32'd1);
    check("d_undef_res", 32'(res), 32'd0);
    check("d_undef_flags", 32'(flags), 32'b0100);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        if (exp_gnt[i]) begin
          r_a[i] = W'($urandom);
          if ($urandom_range(1, 0) == 1) begin
            r_req[i] = 1'b1;
            r_op[i]  = 4'($urandom);
            r_b[i]   = W'($urandom);
          end else begin
            r_req[i] = 1'b0;
          end
        end else if (!r_req[i] && $urandom_range(2, 0) == 0) begin
          set_req(i, 1'b1, 4'($urandom), W'($urandom), W'($urandom));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
